// File: rtl/move_gen_sched.sv
// Move-generator sequencer: hands a board to the generator, then streams
// every resulting position to the consumer and clears the generator RAM.
module move_gen_sched #(
  parameter int PIECE_WIDTH        = 4,
  parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
  parameter int MAX_POSITIONS      = 64,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [BOARD_WIDTH-1:0]        req_board,
  input  logic                          req_white_to_move,
  input  logic [3:0]                    req_castle_mask,
  input  logic [3:0]                    req_en_passant_col,
  output logic                          am_board_valid,
  output logic [BOARD_WIDTH-1:0]        am_board,
  output logic                          am_white_to_move,
  output logic [3:0]                    am_castle_mask,
  output logic [3:0]                    am_en_passant_col,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
  output logic                          am_clear_moves,
  input  logic                          am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
  input  logic [BOARD_WIDTH-1:0]        am_board_out,
  input  logic                          am_white_to_move_out,
  input  logic [3:0]                    am_castle_mask_out,
  input  logic [3:0]                    am_en_passant_col_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BOARD_WIDTH-1:0]        out_board,
  output logic                          out_white_to_move,
  output logic [3:0]                    out_castle_mask,
  output logic [3:0]                    out_en_passant_col,
  output logic [MAX_POSITIONS_LOG2-1:0] out_index,
  output logic                          out_last,
  output logic                          done,
  output logic [MAX_POSITIONS_LOG2-1:0] done_count,
  output logic                          timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = MAX_POSITIONS_LOG2;

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_GEN, ADDR, CAPTURE, PRESENT, CLEAR
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      tcnt               <= '0;
      count              <= '0;
      req_ready          <= 1'b1;
      am_board_valid     <= 1'b0;
      am_board           <= '0;
      am_white_to_move   <= 1'b0;
      am_castle_mask     <= '0;
      am_en_passant_col  <= '0;
      am_move_index      <= '0;
      am_clear_moves     <= 1'b0;
      out_valid          <= 1'b0;
      out_board          <= '0;
      out_white_to_move  <= 1'b0;
      out_castle_mask    <= '0;
      out_en_passant_col <= '0;
      out_index          <= '0;
      out_last           <= 1'b0;
      done               <= 1'b0;
      done_count         <= '0;
      timeout_err        <= 1'b0;
    end else begin
      am_board_valid <= 1'b0;
      am_clear_moves <= 1'b0;
      done           <= 1'b0;
      done_count     <= '0;
      timeout_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          am_move_index <= '0;
          tcnt          <= '0;
          if (req_valid && req_ready) begin
            am_board          <= req_board;
            am_white_to_move  <= req_white_to_move;
            am_castle_mask    <= req_castle_mask;
            am_en_passant_col <= req_en_passant_col;
            req_ready         <= 1'b0;
            am_board_valid    <= 1'b1;
            state             <= LOAD;
          end
        end
        LOAD: state <= WAIT_GEN;
        WAIT_GEN: begin
          tcnt <= tcnt + TW'(1);
          if (am_moves_ready) begin
            count <= am_move_count;
            if (am_move_count == '0) begin
              am_clear_moves <= 1'b1;
              done           <= 1'b1;
              state          <= CLEAR;
            end else begin
              am_move_index <= '0;
              state         <= ADDR;
            end
          end else if (tcnt + TW'(1) == TW'(TIMEOUT_CYCLES - 1)) begin
            // abort: the clear still fires so the generator is recycled
            am_clear_moves <= 1'b1;
            done           <= 1'b1;
            timeout_err    <= 1'b1;
            state          <= CLEAR;
          end
        end
        ADDR: state <= CAPTURE;
        CAPTURE: begin
          out_board          <= am_board_out;
          out_white_to_move  <= am_white_to_move_out;
          out_castle_mask    <= am_castle_mask_out;
          out_en_passant_col <= am_en_passant_col_out;
          out_index          <= am_move_index;
          out_last           <= (am_move_index == count - IW'(1));
          out_valid          <= 1'b1;
          state              <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              am_clear_moves <= 1'b1;
              done           <= 1'b1;
              done_count     <= count;
              state          <= CLEAR;
            end else begin
              am_move_index <= am_move_index + IW'(1);
              state         <= ADDR;
            end
          end
        end
        CLEAR: begin
          tcnt      <= '0;
          count     <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/move_gen_sched.md
Name: move_gen_sched

Overview:
- Sequencing controller for the move-generator block (board in; indexed RAM of resulting positions out).
- Accepts a position request over a valid/ready handshake and holds the board stable for the generator. Waits for the generator's moves-ready flag, then walks the move index from 0 to count-1.
- Streams each resulting position to a downstream consumer with valid/ready backpressure, pulses clear-moves, and returns to idle.
- Sits between the search/root controller and the move generator.

Parameters:
PIECE_WIDTH  `PIECE_BITS  bits per square
BOARD_WIDTH  PIECE_WIDTH*64  packed board width
MAX_POSITIONS  `MAX_POSITIONS  generator RAM depth
MAX_POSITIONS_LOG2  $clog2(MAX_POSITIONS)  index/count width
TIMEOUT_CYCLES  4096  max cycles waiting for moves-ready before abort

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request position valid
req_ready  out  1  controller idle, can accept request
req_board  in  BOARD_WIDTH  position to expand
req_white_to_move  in  1  side to move
req_castle_mask  in  4  castle rights
req_en_passant_col  in  4  en-passant column
am_board_valid  out  1  one-cycle start pulse to generator
am_board  out  BOARD_WIDTH  registered board, stable from start to clear
am_white_to_move  out  1  registered
am_castle_mask  out  4  registered
am_en_passant_col  out  4  registered
am_move_index  out  MAX_POSITIONS_LOG2  RAM read address
am_clear_moves  out  1  one-cycle clear pulse
am_moves_ready  in  1  generator done
am_move_count  in  MAX_POSITIONS_LOG2  number of moves
am_board_out  in  BOARD_WIDTH  RAM data, 1-cycle read latency
am_white_to_move_out  in  1  RAM data
am_castle_mask_out  in  4  RAM data
am_en_passant_col_out  in  4  RAM data
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts
out_board  out  BOARD_WIDTH  resulting position
out_white_to_move  out  1  resulting side to move
out_castle_mask  out  4  resulting castle mask
out_en_passant_col  out  4  resulting en-passant column
out_index  out  MAX_POSITIONS_LOG2  move index of beat
out_last  out  1  beat is index count-1
done  out  1  one-cycle pulse, request finished
done_count  out  MAX_POSITIONS_LOG2  moves delivered, valid with done
timeout_err  out  1  one-cycle pulse with done on abort

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State=IDLE, index=0, timeout counter=0. Reset mid-operation aborts immediately with no done pulse; am_clear_moves is not asserted on reset (generator shares reset).
- IDLE: req_ready=1. On req_valid&&req_ready (cycle T), register board/side/castle/ep; go LOAD.
- LOAD (T+1): am_board_valid=1 for exactly this cycle; req_ready=0 from T+1 until return to IDLE. Go WAIT_GEN.
- WAIT_GEN: increment timeout counter each cycle.
  - am_moves_ready=1: latch am_move_count into count. If count==0 go CLEAR; else index=0 and go ADDR.
  - Counter reaches TIMEOUT_CYCLES-1 without moves_ready: set abort flag, go CLEAR.
- ADDR: am_move_index=index is already driven; wait one cycle for RAM latency; go CAPTURE.
- CAPTURE: load output register from am_*_out, out_index=index, out_last=(index==count-1); out_valid=1; go PRESENT.
- PRESENT: hold all out_* stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: out_valid=0. If out_last go CLEAR; else index+1 and go ADDR.
  - Throughput is one beat per 3 cycles with out_ready tied high.
- CLEAR: am_clear_moves=1 for one cycle; done=1 in the same cycle.
  - done_count = count normally; 0 on abort.
  - timeout_err=1 if aborted.
  - Clear abort flag, counters; go IDLE (req_ready=1 next cycle).
- am_board/side/castle/ep held constant from LOAD through CLEAR.
- am_move_index is registered and changes only in IDLE (0) and on accepted beats.
- Index width arithmetic is modulo 2^MAX_POSITIONS_LOG2. count==MAX_POSITIONS-1 is the largest legal value and is handled via out_last compare, with no wrap.
- am_moves_ready outside WAIT_GEN is ignored. req_valid while busy is ignored (not accepted, req_ready=0).

Test Plan:
- Single request, generator returns count=3, out_ready=1 -> am_board_valid pulse at T+1; beats index 0,1,2 with out_last only on 2; data matches RAM words; am_clear_moves and done with done_count=3 after third accept; req_ready=1 next cycle.
- count=0 -> no out_valid; am_clear_moves+done same cycle with done_count=0; timeout_err=0.
- Backpressure: count=2, out_ready low for 5 cycles on beat 0 -> out_* stable for those cycles, am_move_index stays 0, then beats 0,1 delivered in order.
- Timeout: TIMEOUT_CYCLES=16, moves_ready never asserts -> 16 cycles after LOAD, am_clear_moves, done, timeout_err pulse together; done_count=0.
- Reset asserted during PRESENT of beat 1 of 4 -> next cycle out_valid=0, req_ready=1, no done/clear pulse; new request then completes normally.
- req_valid held high continuously across two requests -> second accepted only the cycle after done; am_board changes only at acceptance.
